// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among N_REQ
//               valid/ready producers. The winner owns the port for a burst
//               of up to MAX_BURST beats, then ownership rotates.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16,
   localparam int GNT_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   input  logic                      fifo_overflow,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_data_in,
   output logic [GNT_W-1:0]          grant_id,
   output logic                      busy,
   output logic [CNT_W-1:0]          wr_count,
   output logic                      err_overflow
);

   localparam int                BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
   localparam logic [GNT_W:0]    N_EXT     = (GNT_W + 1)'(N_REQ);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [GNT_W-1:0]    grant_q, grant_d;
   logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]    wr_count_q, wr_count_d;
   logic                err_ovf_q, err_ovf_d;

   logic                owner_valid;
   logic [DATA_W-1:0]   owner_data;
   logic                ready_en;
   logic                xfer;
   logic [GNT_W-1:0]    release_ptr;
   logic [GNT_W:0]      pick_idle;
   logic [GNT_W:0]      pick_rel;

   // Round-robin search: rotate the request vector so ptr lands at bit 0,
   // take the lowest set bit, then map the offset back to an absolute index.
   // Result is {found, index}.
   function automatic logic [GNT_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [GNT_W-1:0] ptr);
      logic [2*N_REQ-1:0] rot;
      logic               found;
      logic [GNT_W:0]     sum;
      logic [GNT_W-1:0]   idx;
      rot   = {valid, valid} >> ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (GNT_W + 1)'(k);
            if (sum >= N_EXT) begin
               sum = sum - N_EXT;
            end
            idx   = sum[GNT_W-1:0];
         end
      end
      return {found, idx};
   endfunction

   // Select the current owner's valid and data lines.
   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q == GNT_W'(i)) begin
            owner_valid = req_valid[i];
            owner_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign busy         = (state_q == ST_BURST);
   assign ready_en     = busy & ~fifo_full;
   assign xfer         = ready_en & owner_valid;
   assign fifo_wr_en   = xfer;
   assign fifo_data_in = xfer ? owner_data : '0;
   assign grant_id     = grant_q;
   assign wr_count     = wr_count_q;
   assign err_overflow = err_ovf_q;

   // Only the owner's ready bit can be high, and never while the FIFO is full.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = ready_en & (grant_q == GNT_W'(gi));
   end

   // Pointer just past the current owner, used when the grant is released.
   assign release_ptr = (grant_q == GNT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
   assign pick_idle   = rr_pick(req_valid, rr_ptr_q);
   assign pick_rel    = rr_pick(req_valid, release_ptr);

   // Next-state logic: grant, burst release/rotation, counters and error flag.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      wr_count_d = xfer ? wr_count_q + 1'b1 : wr_count_q;
      err_ovf_d  = err_ovf_q | fifo_overflow;

      case (state_q)
         ST_IDLE: begin
            if (pick_idle[GNT_W]) begin
               state_d    = ST_BURST;
               grant_d    = pick_idle[GNT_W-1:0];
               beat_cnt_d = '0;
            end
         end
         ST_BURST: begin
            // Release on burst exhaustion or owner withdrawal; the re-pick
            // happens on the same edge so a waiting requester sees no bubble.
            if (!owner_valid || (xfer && (beat_cnt_q == LAST_BEAT))) begin
               rr_ptr_d   = release_ptr;
               beat_cnt_d = '0;
               if (pick_rel[GNT_W]) begin
                  grant_d = pick_rel[GNT_W-1:0];
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; async assert clears everything, dropping any pending beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         wr_count_q <= '0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         wr_count_q <= wr_count_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed bench for fifo_wr_arbiter. Producers are modelled
//               as per-requester data queues; expected FIFO writes are
//               queued by hand and popped by a monitor on every write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              fifo_full;
   logic              fifo_overflow;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_data_in;
   logic [1:0]        grant_id;
   logic              busy;
   logic [CW-1:0]     wr_count;
   logic              err_overflow;

   int pass_cnt  = 0;
   int chk_cnt   = 0;
   int n_wr      = 0;
   int cyc       = 0;
   int first_cyc = -1;
   int last_cyc  = -1;

   logic [DW-1:0] rq [N][$];
   logic [17:0]   exp_q [$];

   fifo_wr_arbiter #(
      .N_REQ(N), .DATA_W(DW), .MAX_BURST(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
      .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
      .grant_id(grant_id), .busy(busy),
      .wr_count(wr_count), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic expect_wr(input int g, input int d);
      exp_q.push_back({2'(g), 16'(d)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_busy(input string name);
      int n = 0;
      while (busy !== 1'b1 && n < 50) begin tick(); n++; end
      check({name, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || !queues_empty() || busy !== 1'b0) && n < 300) begin
         tick(); n++;
      end
      check({name, "_exp_left"}, exp_q.size(), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   // Producer model: present queue head; pop when the handshake completes.
   initial begin : drv
      logic [N-1:0] fire;
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            req_valid[i]           = (rq[i].size() > 0);
            req_data[i*DW +: DW]   = (rq[i].size() > 0) ? rq[i][0] : '0;
         end
         #2 fire = req_valid & req_ready;
         @(posedge clk);
         for (int i = 0; i < N; i++)
            if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
   end

   // Monitor: every FIFO write must match the next expected (grant, data).
   initial begin : mon
      logic [17:0] e;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
            check("wr_while_full", 32'(fifo_full), 32'd0);
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_write: got data 0x%0h grant %0d, expected no write",
                        fifo_data_in, grant_id);
            end else begin
               e = exp_q.pop_front();
               check("wr_grant", 32'(grant_id), 32'(e[17:16]));
               check("wr_data", 32'(fifo_data_in), 32'(e[15:0]));
            end
            n_wr++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         if (rst_n === 1'b1 && req_ready != '0)
            check("ready_onehot", $countones(req_ready), 32'd1);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      int start;
      int n;
      fifo_full     = 1'b0;
      fifo_overflow = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_data", 32'(fifo_data_in), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      check("rst_err", 32'(err_overflow), 32'd0);
      rst_n = 1'b1;
      tick();

      // All four requesters, 8 beats each: 0,1,2,3,0,1,2,3 with 4 beats per grant.
      first_cyc = -1;
      for (int q = 0; q < N; q++)
         for (int k = 0; k < 8; k++) rq[q].push_back(16'((q << 12) | k));
      for (int r = 0; r < 2; r++)
         for (int q = 0; q < N; q++)
            for (int b = 0; b < 4; b++) expect_wr(q, (q << 12) | (r*4 + b));
      wait_done("all4");
      check("all4_wr_count", 32'(wr_count), 32'd32);
      check("all4_contiguous", last_cyc - first_cyc + 1, 32'd32);

      // Sole requester 2: re-granted to itself after 4 beats without a bubble.
      first_cyc = -1;
      for (int k = 0; k < 6; k++) begin
         rq[2].push_back(16'(16'hA000 + k));
         expect_wr(2, 16'hA000 + k);
      end
      wait_done("solo2");
      check("solo2_wr_count", 32'(wr_count), 32'd38);
      check("solo2_contiguous", last_cyc - first_cyc + 1, 32'd6);

      // Reset in the middle of a burst from requester 1 (beat 2 pending).
      for (int k = 0; k < 8; k++) rq[1].push_back(16'(16'h1000 + k));
      expect_wr(1, 16'h1000);
      expect_wr(1, 16'h1001);
      start = n_wr;
      n = 0;
      while (n_wr < start + 2 && n < 50) begin @(negedge clk); #3; n++; end
      @(posedge clk);
      #1;
      check("mid_pending_beat", 32'(fifo_wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("mid_rst_data", 32'(fifo_data_in), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) rq[i].delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_wr_count", 32'(wr_count), 32'd0);
      check("post_rst_grant", 32'(grant_id), 32'd0);
      check("post_rst_exp_left", exp_q.size(), 32'd0);
      // Pointer was 3 before reset; after reset it must be 0 so req 0 wins first.
      rq[0].push_back(16'h0B01);
      rq[3].push_back(16'h3B01);
      expect_wr(0, 16'h0B01);
      expect_wr(3, 16'h3B01);
      wait_done("rrptr");
      check("rrptr_wr_count", 32'(wr_count), 32'd2);

      // Req 0 bursting with fifo_full held for four cycles after two beats.
      for (int k = 0; k < 6; k++) rq[0].push_back(16'(16'h4000 + k));
      rq[1].push_back(16'h4100);
      for (int k = 0; k < 4; k++) expect_wr(0, 16'h4000 + k);
      expect_wr(1, 16'h4100);
      expect_wr(0, 16'h4004);
      expect_wr(0, 16'h4005);
      wait_busy("full");
      check("full_grant", 32'(grant_id), 32'd0);
      tick();
      tick();
      fifo_full = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("full_ready", 32'(req_ready), 32'd0);
         check("full_wr_en", 32'(fifo_wr_en), 32'd0);
         check("full_hold_grant", 32'(grant_id), 32'd0);
         @(posedge clk);
         #1;
      end
      fifo_full = 1'b0;
      wait_done("full");
      check("full_wr_count", 32'(wr_count), 32'd9);

      // Req 3 withdraws after one beat while req 1 waits: same-edge hand-over.
      rq[3].push_back(16'h5300);
      expect_wr(3, 16'h5300);
      expect_wr(1, 16'h5100);
      expect_wr(1, 16'h5101);
      wait_busy("drop");
      rq[1].push_back(16'h5100);
      rq[1].push_back(16'h5101);
      @(negedge clk); #3;
      check("drop_beat_grant", 32'(grant_id), 32'd3);
      @(negedge clk); #3;
      check("drop_release_wr_en", 32'(fifo_wr_en), 32'd0);
      check("drop_release_grant", 32'(grant_id), 32'd3);
      @(negedge clk); #3;
      check("drop_new_grant", 32'(grant_id), 32'd1);
      check("drop_new_wr_en", 32'(fifo_wr_en), 32'd1);
      wait_done("drop");
      check("drop_wr_count", 32'(wr_count), 32'd12);

      // Sticky overflow flag, cleared only by reset.
      check("ovf_before", 32'(err_overflow), 32'd0);
      @(negedge clk);
      fifo_overflow = 1'b1;
      @(negedge clk);
      fifo_overflow = 1'b0;
      #1;
      check("ovf_set", 32'(err_overflow), 32'd1);
      repeat (5) tick();
      check("ovf_sticky", 32'(err_overflow), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ovf_rst", 32'(err_overflow), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ovf_after_rst", 32'(err_overflow), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
